// File: rtl/spi_seq_pkg.sv
// Shared types for the table-driven SPI command sequencer: opcodes, FSM states
// and the table entry layout at the default 8-bit payload width.
package spi_seq_pkg;

    localparam int SEQ_OP_W   = 2;
    localparam int SEQ_DATA_W = 8;

    typedef enum logic [SEQ_OP_W-1:0] {
        OP_SEND_CMD  = 2'b00,
        OP_SEND_DATA = 2'b01,
        OP_DELAY     = 2'b10,
        OP_END       = 2'b11
    } seq_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STARTWAIT,
        ST_FETCH,
        ST_DECODE,
        ST_SEND,
        ST_WAIT,
        ST_DELAY,
        ST_FINISH
    } seq_state_e;

    typedef struct packed {
        seq_op_e                 op;
        logic [SEQ_DATA_W-1:0]   payload;
    } seq_entry_t;

endpackage

// File: rtl/seq_delay_timer.sv
// DELAY entry timer: outer unit down-counter driven by a DELAY_SCALE prescaler,
// so payload*DELAY_SCALE cycles are timed without a multiplier.
module seq_delay_timer
    import spi_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DELAY_SCALE = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              run,
    input  logic [DATA_W-1:0] payload,
    output logic              expired
);

    localparam int PRE_W = (DELAY_SCALE > 1) ? $clog2(DELAY_SCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LOAD = PRE_W'(DELAY_SCALE - 1);

    logic [DATA_W-1:0] unit_q, unit_d;
    logic [PRE_W-1:0]  pre_q, pre_d;

    // Terminal count is the last prescaler tick of the last unit; a zero
    // payload is already expired on its first cycle.
    assign expired = (unit_q == '0) || ((unit_q == DATA_W'(1)) && (pre_q == '0));

    always_comb begin
        unit_d = unit_q;
        pre_d  = pre_q;
        if (load) begin
            unit_d = payload;
            pre_d  = PRE_LOAD;
        end else if (run && !expired) begin
            if (pre_q == '0) begin
                pre_d  = PRE_LOAD;
                unit_d = unit_q - DATA_W'(1);
            end else begin
                pre_d = pre_q - PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            unit_q <= '0;
            pre_q  <= '0;
        end else begin
            unit_q <= unit_d;
            pre_q  <= pre_d;
        end
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Walks a command ROM and feeds spi_controller one byte per SEND entry.
// Optional SPI_SEQ_LOOP_EN: an END entry with loop=1 restarts at address 0.
//
// state     | meaning
// IDLE      | waiting for go
// STARTWAIT | settle delay after go
// FETCH     | rom_addr presented, ROM latency cycle
// DECODE    | entry on rom_data, dispatch on opcode
// SEND      | waiting for controller idle, then spi_start
// WAIT      | waiting for spi_done
// DELAY     | timing a DELAY entry
// FINISH    | seq_done pulse
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int DELAY_SCALE = 1024,
    parameter int START_DELAY = 10,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                go,
    input  logic                loop,
    output logic [AW-1:0]       rom_addr,
    input  logic [DATA_W+1:0]   rom_data,
    output logic                spi_start,
    output logic [DATA_W-1:0]   spi_data,
    output logic                spi_dc,
    input  logic                spi_busy,
    input  logic                spi_done,
    output logic                seq_busy,
    output logic                seq_done,
    output logic                seq_err
);

    localparam int SW_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [SW_W-1:0] SW_LOAD = (START_DELAY > 0) ? SW_W'(START_DELAY - 1) : '0;

    seq_state_e          state_q, state_d;
    logic [AW-1:0]       rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0]   spi_data_q, spi_data_d;
    logic                spi_dc_q, spi_dc_d;
    logic                seq_err_q, seq_err_d;
    logic [SW_W-1:0]     sw_cnt_q, sw_cnt_d;

    seq_op_e             op;
    logic [DATA_W-1:0]   payload;
    logic                tmr_load;
    logic                tmr_run;
    logic                tmr_expired;
    logic                advance;
    logic                last_addr;
    logic                start;

    assign op        = seq_op_e'(rom_data[DATA_W +: SEQ_OP_W]);
    assign payload   = rom_data[DATA_W-1:0];
    assign last_addr = (rom_addr_q == AW'(DEPTH - 1));
    assign tmr_load  = (state_q == ST_DECODE) && (op == OP_DELAY);
    assign tmr_run   = (state_q == ST_DELAY);

`ifndef SPI_SEQ_LOOP_EN
    logic unused_loop;
    assign unused_loop = loop;
`endif

    seq_delay_timer #(
        .DATA_W      (DATA_W),
        .DELAY_SCALE (DELAY_SCALE)
    ) u_delay_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .run     (tmr_run),
        .payload (payload),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        spi_data_d = spi_data_q;
        spi_dc_d   = spi_dc_q;
        seq_err_d  = seq_err_q;
        sw_cnt_d   = sw_cnt_q;
        start      = 1'b0;
        advance    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d    = ST_STARTWAIT;
                    seq_err_d  = 1'b0;
                    rom_addr_d = '0;
                    sw_cnt_d   = SW_LOAD;
                end
            end
            ST_STARTWAIT: begin
                if (sw_cnt_q == '0) begin
                    state_d = ST_FETCH;
                end else begin
                    sw_cnt_d = sw_cnt_q - SW_W'(1);
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                case (op)
                    OP_SEND_CMD, OP_SEND_DATA: begin
                        spi_data_d = payload;
                        spi_dc_d   = (op == OP_SEND_DATA);
                        state_d    = ST_SEND;
                    end
                    OP_DELAY: state_d = ST_DELAY;
                    default: begin
`ifdef SPI_SEQ_LOOP_EN
                        if (loop) begin
                            rom_addr_d = '0;
                            state_d    = ST_FETCH;
                        end else begin
                            state_d = ST_FINISH;
                        end
`else
                        state_d = ST_FINISH;
`endif
                    end
                endcase
            end
            ST_SEND: begin
                if (!spi_busy) begin
                    start   = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT:   advance = spi_done;
            ST_DELAY:  advance = tmr_expired;
            ST_FINISH: begin
                rom_addr_d = '0;
                state_d    = ST_IDLE;
            end
            default:   state_d = ST_IDLE;
        endcase

        // Running off the end of the table is an error rather than a wrap.
        if (advance) begin
            if (last_addr) begin
                seq_err_d = 1'b1;
                state_d   = ST_FINISH;
            end else begin
                rom_addr_d = rom_addr_q + AW'(1);
                state_d    = ST_FETCH;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            spi_data_q <= '0;
            spi_dc_q   <= 1'b0;
            seq_err_q  <= 1'b0;
            sw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            spi_data_q <= spi_data_d;
            spi_dc_q   <= spi_dc_d;
            seq_err_q  <= seq_err_d;
            sw_cnt_q   <= sw_cnt_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign spi_data  = spi_data_q;
    assign spi_dc    = spi_dc_q;
    assign seq_err   = seq_err_q;
    assign spi_start = start;
    assign seq_busy  = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign seq_done  = (state_q == ST_FINISH);

endmodule
